axi_stream_frame_source: RTL and testbench

AXI_STREAM_FRAME_SOURCE -- requirements
Module: axi_stream_frame_source

---
 rtl/axi_frame_pkg.sv | 10 +
 rtl/frame_pos_counter.sv | 28 ++
 rtl/axi_stream_frame_source.sv | 112 +++++++++++
 tb/tb_axi_stream_frame_source.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_frame_pkg.sv
// axi_frame_pkg: shared types for the AXI-Stream frame source
package axi_frame_pkg;
    localparam int POS_WIDTH = 16;
    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
    typedef enum logic [1:0] {COUNTER, COORD, CONST, FRAMEID} mode_t;
    typedef struct packed {
        logic [POS_WIDTH-1:0] x_max;
        logic [POS_WIDTH-1:0] y_max;
    } pos_dims_t;
endpackage

// File: rtl/frame_pos_counter.sv
// frame_pos_counter: pixel/line position tracker with wrap at frame dimensions
module frame_pos_counter
    import axi_frame_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 advance,
    input  logic                 clear,
    input  pos_dims_t            dims,
    output logic [POS_WIDTH-1:0] x,
    output logic [POS_WIDTH-1:0] y,
    output logic                 last_in_line,
    output logic                 last_in_frame
);
    assign last_in_line  = x == dims.x_max;
    assign last_in_frame = last_in_line && y == dims.y_max;
    // step x per accepted beat, carrying into y at end of line and wrapping both at end of frame
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            x <= last_in_line ? '0 : x + POS_WIDTH'(1);
            if (last_in_line)
                y <= last_in_frame ? '0 : y + POS_WIDTH'(1);
        end
    end
endmodule

// File: rtl/axi_stream_frame_source.sv
// axi_stream_frame_source: AXI4-Stream test-pattern generator emitting fixed-size frames
module axi_stream_frame_source
    import axi_frame_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int PIXELS_PER_LINE = 8,
    parameter int LINES_PER_FRAME = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] const_value,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  frame_done,
    output logic [15:0]           frame_count
);
    localparam pos_dims_t DIMS = '{x_max: POS_WIDTH'(PIXELS_PER_LINE - 1),
                                   y_max: POS_WIDTH'(LINES_PER_FRAME - 1)};

    state_t                 state;
    mode_t                  mode_q;
    logic [DATA_WIDTH-1:0]  beat_cnt;
    logic [DATA_WIDTH-1:0]  pattern;
    logic [7:0]             gap_cnt;
    logic [POS_WIDTH-1:0]   x;
    logic [POS_WIDTH-1:0]   y;
    logic                   last_in_line;
    logic                   last_in_frame;
    logic                   hs;
    logic                   eof;

    assign hs  = m_axis_tvalid && m_axis_tready;
    assign eof = hs && last_in_frame;

    frame_pos_counter u_pos (
        .clk           (clk),
        .rst_n         (rst_n),
        .advance       (hs),
        .clear         (state != ACTIVE),
        .dims          (DIMS),
        .x             (x),
        .y             (y),
        .last_in_line  (last_in_line),
        .last_in_frame (last_in_frame)
    );

    // payload for the latched mode; everything but CONST is derived from registers so it holds under stall
    always_comb begin
        pattern = mode_q == COUNTER ? beat_cnt :
                  mode_q == COORD   ? DATA_WIDTH'({y, x}) :
                  mode_q == CONST   ? const_value :
                                      DATA_WIDTH'({frame_count, x});
    end

    assign m_axis_tvalid = state == ACTIVE;
    assign m_axis_tdata  = m_axis_tvalid ? pattern : '0;
    assign m_axis_tlast  = m_axis_tvalid && last_in_line;
    assign m_axis_tuser  = m_axis_tvalid && x == '0 && y == '0;

    // frame sequencer: only leaves ACTIVE at a frame boundary, so frames are never truncated
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_q      <= COUNTER;
            beat_cnt    <= '0;
            frame_count <= '0;
            frame_done  <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            frame_done <= eof;
            if (hs)
                beat_cnt <= beat_cnt + DATA_WIDTH'(1);
            if (eof)
                frame_count <= frame_count + 16'd1;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state  <= ACTIVE;
                        mode_q <= mode_t'(mode);
                    end
                end
                ACTIVE: begin
                    if (eof) begin
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= 8'(GAP_CYCLES - 1);
                        end else if (enable) begin
                            mode_q <= mode_t'(mode);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state  <= enable ? ACTIVE : IDLE;
                        mode_q <= mode_t'(mode);
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_stream_frame_source.sv
// tb_axi_stream_frame_source: scoreboard bench for the frame source with a frame-level reference model
module tb_axi_stream_frame_source;
    localparam int DW    = 32;
    localparam int PPL   = 4;
    localparam int LPF   = 2;
    localparam int GAP_N = 2;
    localparam int BEATS = PPL * LPF;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] const_value = '0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b0;
    logic          tlast;
    logic          tuser;
    logic          frame_done;
    logic [15:0]   frame_count;

    int            tests = 0;
    int            fails = 0;
    beat_t         exp_q[$];
    beat_t         mon_e;
    int            popped = 0;
    int            done_pulses = 0;
    logic [DW-1:0] m_beat = '0;
    logic [15:0]   m_fc = '0;
    int            ready_pat = 0;

    always #5 clk = ~clk;

    axi_stream_frame_source #(
        .DATA_WIDTH      (DW),
        .PIXELS_PER_LINE (PPL),
        .LINES_PER_FRAME (LPF),
        .GAP_CYCLES      (GAP_N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .mode          (mode),
        .const_value   (const_value),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser),
        .frame_done    (frame_done),
        .frame_count   (frame_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: a whole frame of expected beats from the pattern definitions
    task automatic push_frame(input logic [1:0] m);
        for (int i = 0; i < BEATS; i++) begin
            beat_t b;
            int px;
            int py;
            px = i % PPL;
            py = i / PPL;
            b.last = (px == PPL - 1);
            b.user = (i == 0);
            case (m)
                2'd0:    b.data = m_beat;
                2'd1:    b.data = DW'(py * 65536 + px);
                2'd2:    b.data = const_value;
                default: b.data = {m_fc, 16'(px)};
            endcase
            m_beat = m_beat + 1;
            exp_q.push_back(b);
        end
        m_fc = m_fc + 1;
    endtask

    task automatic wait_pops(input int target, input string name);
        int c;
        c = 0;
        do begin
            @(posedge clk);
            c++;
        end while (popped < target && c < 3000);
        #2;
        check({name, "_progress"}, popped >= target, 1);
    endtask

    task automatic run_frames(input int n, input logic [1:0] m0, input logic [1:0] m1,
                              input int sw, input int d, input int pat, input bit chk);
        int base;
        logic [15:0] fc0;
        ready_pat = pat;
        mode = m0;
        base = popped;
        fc0 = m_fc;
        push_frame(m0);
        for (int f = 1; f < n; f++) push_frame(m1);
        @(posedge clk);
        #2 enable = 1'b1;
        if (chk) begin
            int c;
            int low;
            c = 0;
            low = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!frame_done && c < 200);
            check("frame_done_seen", frame_done, 1);
            check("frame_count_first", frame_count, fc0 + 16'd1);
            while (!tvalid && low < 10) begin
                low++;
                @(negedge clk);
            end
            check("gap_cycles", low, GAP_N);
        end
        if (sw > 0) begin
            wait_pops(base + sw, "mode_switch");
            mode = m1;
        end
        wait_pops(base + (n - 1) * BEATS + d, "enable_drop");
        enable = 1'b0;
        wait_pops(base + n * BEATS, "frames_out");
        repeat (8) @(posedge clk);
        #2;
        check("idle_tvalid", tvalid, 0);
        check("frame_count", frame_count, m_fc);
        check("done_pulses", done_pulses, m_fc);
        check("queue_empty", exp_q.size(), 0);
    endtask

    // sink readiness: always, the 1,0,0,1 pattern, or random
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_pat)
                0:       tready = 1'b1;
                1:       tready = (phase == 0 || phase == 3);
                default: tready = 1'($urandom_range(0, 1));
            endcase
            phase = (phase + 1) % 4;
        end
    end

    // monitor: pops the scoreboard on every handshake and checks stall stability
    initial begin
        logic          pv;
        logic [DW-1:0] pd;
        logic          pl;
        logic          pu;
        pv = 1'b0;
        pd = '0;
        pl = 1'b0;
        pu = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_done) done_pulses++;
            if (pv) begin
                check("stall_tvalid", tvalid, 1);
                check("stall_tdata", tdata, pd);
                check("stall_tlast", tlast, pl);
                check("stall_tuser", tuser, pu);
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tdata", tdata, mon_e.data);
                    check("tlast", tlast, mon_e.last);
                    check("tuser", tuser, mon_e.user);
                    popped++;
                end
            end
            pv = tvalid && !tready && rst_n;
            pd = tdata;
            pl = tlast;
            pu = tuser;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tuser", tuser, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        run_frames(2, 2'd0, 2'd0, 0, 1, 0, 1'b1);
        run_frames(1, 2'd0, 2'd0, 0, 1, 1, 1'b0);
        run_frames(1, 2'd1, 2'd1, 0, 1, 0, 1'b0);
        run_frames(1, 2'd0, 2'd0, 0, 3, 0, 1'b0);
        const_value = 32'hA5A5A5A5;
        run_frames(2, 2'd0, 2'd2, 3, 1, 0, 1'b0);

        ready_pat = 0;
        mode = 2'd0;
        base = popped;
        push_frame(2'd0);
        @(posedge clk);
        #2 enable = 1'b1;
        wait_pops(base + 5, "pre_reset");
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        m_beat = '0;
        m_fc = '0;
        done_pulses = 0;
        @(negedge clk);
        check("mid_rst_tvalid", tvalid, 0);
        check("mid_rst_tdata", tdata, 0);
        check("mid_rst_frame_count", frame_count, 0);
        check("mid_rst_frame_done", frame_done, 0);
        base = popped;
        push_frame(2'd0);
        wait_pops(base + 1, "restart");
        enable = 1'b0;
        wait_pops(base + BEATS, "restart_frame");
        repeat (8) @(posedge clk);
        #2;
        check("restart_idle", tvalid, 0);
        check("restart_frame_count", frame_count, m_fc);
        check("restart_done_pulses", done_pulses, m_fc);

        for (int k = 0; k < 10; k++) begin
            int n;
            int sw;
            logic [1:0] m0;
            logic [1:0] m1;
            n = $urandom_range(1, 3);
            m0 = 2'($urandom_range(0, 3));
            m1 = 2'($urandom_range(0, 3));
            sw = (n > 1) ? $urandom_range(1, 7) : 0;
            const_value = DW'($urandom);
            run_frames(n, m0, m1, sw, $urandom_range(1, 7), $urandom_range(0, 2), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
